// File: rtl/cryptoveril_forward_pkg.sv
// Shared constants for the cryptoveril forward/reverse pair: mode encodings,
// masks, sign-extension position and key field layout.
package cryptoveril_forward_pkg;

  typedef enum logic [1:0] {
    MODE_PARITY = 2'd0,
    MODE_AND    = 2'd1,
    MODE_OR     = 2'd2,
    MODE_SEXT   = 2'd3
  } mode_e;

  localparam logic [15:0] MASK_AND = 16'hAAAA;
  localparam logic [15:0] MASK_OR  = 16'h5555;

  localparam int SEXT_BIT = 11;

  localparam int KEY_W       = 6;
  localparam int KEY_SH_HI   = 5;
  localparam int KEY_SH_LO   = 3;
  localparam int KEY_MODE_HI = 2;
  localparam int KEY_MODE_LO = 1;
  localparam int KEY_RSVD    = 0;

  // Replicate bit SEXT_BIT into the upper nibble, keeping the low 12 bits.
  function automatic logic [15:0] sext12(input logic [15:0] v);
    return {{(15 - SEXT_BIT){v[SEXT_BIT]}}, v[SEXT_BIT:0]};
  endfunction

endpackage

// File: rtl/cryptoveril_mode_xform.sv
// Pure combinational mode transform applied in stage 2 of the forward pipe.
module cryptoveril_mode_xform
  import cryptoveril_forward_pkg::*;
(
  input  logic [15:0] s1,
  input  logic [1:0]  mode,
  output logic [15:0] s2
);

  // Select the stage-2 transform for this word's mode.
  always_comb begin
    s2 = s1;
    case (mode_e'(mode))
      MODE_PARITY: s2 = {15'd0, ^s1};
      MODE_AND:    s2 = s1 & MASK_AND;
      MODE_OR:     s2 = s1 | MASK_OR;
      MODE_SEXT:   s2 = sext12(s1);
      default:     s2 = s1;
    endcase
  end

endmodule

// File: rtl/cryptoveril_forward.sv
// Three-stage forward encryption pipeline with a single global stall driven
// by output backpressure. Each word carries its own key through the stages.
module cryptoveril_forward
  import cryptoveril_forward_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] plain_data,
  input  logic [5:0]  key_bits,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] encrypted_data,
  output logic [5:0]  key_out,
  output logic        lossy,
  output logic [15:0] word_count
);

  logic        s1_valid_q, s1_valid_d;
  logic [15:0] s1_data_q,  s1_data_d;
  logic [5:0]  s1_key_q,   s1_key_d;

  logic        s2_valid_q, s2_valid_d;
  logic [15:0] s2_data_q,  s2_data_d;
  logic [5:0]  s2_key_q,   s2_key_d;

  logic        s3_valid_q, s3_valid_d;
  logic [15:0] s3_data_q,  s3_data_d;
  logic [5:0]  s3_key_q,   s3_key_d;
  logic        s3_lossy_q, s3_lossy_d;

  logic [15:0] word_count_q, word_count_d;

  logic        stall;
  logic [2:0]  in_sh;
  logic [15:0] shifted;
  logic [15:0] s1_calc;
  logic [15:0] xform_out;
  mode_e       s2_mode;

  cryptoveril_mode_xform u_xform (
    .s1   (s1_data_q),
    .mode (s1_key_q[KEY_MODE_HI:KEY_MODE_LO]),
    .s2   (xform_out)
  );

  // Stall, stage arithmetic and next-state for every pipeline register.
  always_comb begin
    stall   = s3_valid_q && !out_ready;
    in_sh   = key_bits[KEY_SH_HI:KEY_SH_LO];
    shifted = plain_data << in_sh;
    s1_calc = shifted + {13'd0, in_sh};
    s2_mode = mode_e'(s2_key_q[KEY_MODE_HI:KEY_MODE_LO]);

    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_key_d   = s1_key_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_key_d   = s2_key_q;
    s3_valid_d = s3_valid_q;
    s3_data_d  = s3_data_q;
    s3_key_d   = s3_key_q;
    s3_lossy_d = s3_lossy_q;

    if (!stall) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = s1_calc;
        s1_key_d  = key_bits;
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = xform_out;
        s2_key_d  = s1_key_q;
      end
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        s3_data_d  = (s2_mode == MODE_SEXT) ? sext12(s2_data_q) : s2_data_q;
        s3_key_d   = s2_key_q;
        s3_lossy_d = (s2_mode == MODE_PARITY);
      end
    end

    word_count_d = word_count_q;
    if (s3_valid_q && out_ready) begin
      word_count_d = word_count_q + 16'd1;
    end
  end

  // Pipeline and counter registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_key_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_key_q     <= '0;
      s3_valid_q   <= 1'b0;
      s3_data_q    <= '0;
      s3_key_q     <= '0;
      s3_lossy_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_key_q     <= s1_key_d;
      s2_valid_q   <= s2_valid_d;
      s2_data_q    <= s2_data_d;
      s2_key_q     <= s2_key_d;
      s3_valid_q   <= s3_valid_d;
      s3_data_q    <= s3_data_d;
      s3_key_q     <= s3_key_d;
      s3_lossy_q   <= s3_lossy_d;
      word_count_q <= word_count_d;
    end
  end

  assign in_ready       = !stall;
  assign out_valid      = s3_valid_q;
  assign encrypted_data = s3_data_q;
  assign key_out        = s3_key_q;
  assign lossy          = s3_lossy_q;
  assign word_count     = word_count_q;

endmodule

// File: tb/tb_cryptoveril_forward.sv
// Scoreboard bench for cryptoveril_forward: the driver pushes reference
// results on acceptance, an independent monitor pops them on delivery.
module tb_cryptoveril_forward;

  typedef struct packed {
    logic [15:0] data;
    logic [5:0]  key;
    logic        lossy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] plain_data = '0;
  logic [5:0]  key_bits = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] encrypted_data;
  logic [5:0]  key_out;
  logic        lossy;
  logic [15:0] word_count;

  int          compared = 0;
  int          mismatched = 0;
  exp_t        sb[$];
  logic [15:0] model_count = '0;
  bit          rand_ready = 1'b0;

  cryptoveril_forward dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .plain_data     (plain_data),
    .key_bits       (key_bits),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .encrypted_data (encrypted_data),
    .key_out        (key_out),
    .lossy          (lossy),
    .word_count     (word_count)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Reference: arithmetic reading of the transform rules, no bit-level reuse.
  function automatic int unsigned sext_ref(input int unsigned v);
    if (((v / 2048) % 2) == 1) return (v % 4096) + 32'hF000;
    return v % 4096;
  endfunction

  function automatic exp_t model(input logic [15:0] p, input logic [5:0] k);
    int unsigned sh, mode, v;
    logic [15:0] t;
    exp_t e;
    sh   = k / 8;
    mode = (k / 2) % 4;
    v    = ((p * (32'd1 << sh)) + sh) % 65536;
    case (mode)
      0: begin t = v[15:0]; v = $countones(t) % 2; end
      1: v = v & 32'hAAAA;
      2: v = v | 32'h5555;
      default: v = sext_ref(sext_ref(v));
    endcase
    e.data  = v[15:0];
    e.key   = k;
    e.lossy = (mode == 0);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Offer one word, holding it until accepted; in_valid drops after the accepting edge.
  task automatic applyStimulus(input logic [15:0] d, input logic [5:0] k);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      in_valid   = 1'b1;
      plain_data = d;
      key_bits   = k;
      #4;
      if (in_ready) begin
        sb.push_back(model(d, k));
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0 expected 1");
    end
  endtask

  task automatic sampleCycle(output logic ov);
    @(negedge clk);
    #4;
    ov = out_valid;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout: %0d words outstanding expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset between clock edges, with immediate output checks.
  task automatic doReset();
    @(negedge clk);
    #2;
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    model_count = '0;
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_word_count", {16'd0, word_count}, 32'd0);
    checkOutput("rst_encrypted", {16'd0, encrypted_data}, 32'd0);
    checkOutput("rst_key_out", {26'd0, key_out}, 32'd0);
    checkOutput("rst_lossy", {31'd0, lossy}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Random backpressure generator, active only when enabled.
  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor: compares each delivered word and checks hold-stability during stalls.
  initial begin
    exp_t e;
    bit prev_stall;
    logic [15:0] held_data;
    logic [5:0]  held_key;
    logic        held_lossy;
    prev_stall = 1'b0;
    held_data  = '0;
    held_key   = '0;
    held_lossy = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checkOutput("stall_hold_data", {16'd0, encrypted_data}, {16'd0, held_data});
          checkOutput("stall_hold_key", {26'd0, key_out}, {26'd0, held_key});
          checkOutput("stall_hold_lossy", {31'd0, lossy}, {31'd0, held_lossy});
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_output: got %h expected no word", encrypted_data);
          end else begin
            e = sb.pop_front();
            checkOutput("data", {16'd0, encrypted_data}, {16'd0, e.data});
            checkOutput("key_out", {26'd0, key_out}, {26'd0, e.key});
            checkOutput("lossy", {31'd0, lossy}, {31'd0, e.lossy});
          end
          checkOutput("word_count", {16'd0, word_count}, {16'd0, model_count});
          model_count = model_count + 16'd1;
        end
        prev_stall = out_valid && !out_ready;
        held_data  = encrypted_data;
        held_key   = key_out;
        held_lossy = lossy;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence: directed vectors, backpressure, mid-run reset, random, wrap.
  initial begin
    logic ov;
    int   acc;
    logic [15:0] bp_data [5];
    logic [5:0]  k;

    doReset();
    out_ready = 1'b1;

    applyStimulus(16'h0003, 6'b001010);
    sampleCycle(ov); checkOutput("lat_c1", {31'd0, ov}, 32'd0);
    sampleCycle(ov); checkOutput("lat_c2", {31'd0, ov}, 32'd0);
    sampleCycle(ov); checkOutput("lat_c3", {31'd0, ov}, 32'd1);
    drain();

    applyStimulus(16'h0100, 6'b010110);
    applyStimulus(16'h0300, 6'b010110);
    sampleCycle(ov); checkOutput("b2b_c1", {31'd0, ov}, 32'd0);
    sampleCycle(ov); checkOutput("b2b_c2", {31'd0, ov}, 32'd1);
    sampleCycle(ov); checkOutput("b2b_c3", {31'd0, ov}, 32'd1);
    drain();

    applyStimulus(16'h0000, 6'b000100);
    applyStimulus(16'h0001, 6'b000000);
    drain();

    doReset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) bp_data[i] = 16'($urandom);
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid   = 1'b1;
      plain_data = bp_data[acc];
      key_bits   = 6'(c * 13 + 3);
      #4;
      if (in_ready) begin
        sb.push_back(model(plain_data, key_bits));
        acc++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    checkOutput("bp_accepted", acc, 3);
    checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (4) @(negedge clk);
    out_ready = 1'b1;
    for (int i = acc; i < 5; i++) applyStimulus(bp_data[i], 6'(i * 7 + 1));
    drain();
    checkOutput("bp_word_count", {16'd0, word_count}, 32'd5);

    applyStimulus(16'h1234, 6'b011010);
    applyStimulus(16'h4321, 6'b100100);
    doReset();
    repeat (8) @(negedge clk);
    checkOutput("post_rst_count", {16'd0, word_count}, 32'd0);

    rand_ready = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
      end else begin
        k = 6'($urandom);
        applyStimulus(16'($urandom), k);
      end
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    doReset();
    out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) applyStimulus(16'($urandom), 6'($urandom));
    drain();
    checkOutput("wrap_ffff", {16'd0, word_count}, 32'h0000FFFF);
    applyStimulus(16'h00A5, 6'b001110);
    drain();
    checkOutput("wrap_zero", {16'd0, word_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
